// File: rtl/dcache_pkg.sv
// Shared types and address-field width helpers for the direct-mapped data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  localparam int MEM_WORD_BYTES = 4;

  function automatic int byte_sel_w();
    return $clog2(MEM_WORD_BYTES);
  endfunction

  function automatic int word_sel_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines, input int words);
    return addr_w - $clog2(MEM_WORD_BYTES) - $clog2(words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid bits, tag RAM and data RAM for the cache; combinational read, separate
// word-write and line-fill ports, synchronous clear of all valid bits.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 32,
  localparam int WSEL_W = word_sel_w(WORDS),
  localparam int IDX_W  = index_w(LINES),
  localparam int TAG_W  = tag_w(ADDR_W, LINES, WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic [WSEL_W-1:0] rd_word,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [WSEL_W-1:0] wr_word,
  input  logic [31:0]       wr_data,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_index,
  input  logic [TAG_W-1:0]  fill_tag
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES][WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[fill_index] <= 1'b1;
    end
  end

  // Tag and data contents are not reset; only the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[fill_index] <= fill_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data[wr_index][wr_word] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index][rd_word];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller:
// FSM, refill beat counter and registered memory-side request.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int BSEL_W = byte_sel_w();
  localparam int WSEL_W = word_sel_w(WORDS);
  localparam int IDX_W  = index_w(LINES);
  localparam int TAG_W  = tag_w(ADDR_W, LINES, WORDS);
  localparam int OFF_W  = BSEL_W + WSEL_W;
  localparam logic [WSEL_W-1:0] LAST_BEAT = WSEL_W'(WORDS - 1);

  state_t state, next_state;
  logic [WSEL_W-1:0] beat;

  logic [WSEL_W-1:0] cpu_word;
  logic [IDX_W-1:0]  cpu_index;
  logic [TAG_W-1:0]  cpu_tag;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] word_addr;
  logic              unused_byte_sel;

  assign cpu_word        = cpu_addr[BSEL_W +: WSEL_W];
  assign cpu_index       = cpu_addr[OFF_W +: IDX_W];
  assign cpu_tag         = cpu_addr[ADDR_W-1 -: TAG_W];
  assign line_base       = {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign word_addr       = {cpu_addr[ADDR_W-1:BSEL_W], {BSEL_W{1'b0}}};
  assign unused_byte_sel = ^cpu_addr[BSEL_W-1:0];

  // Refill placement comes from the in-flight memory address, not cpu_addr,
  // so a misbehaving pipeline cannot scatter one line across two indices.
  logic [IDX_W-1:0] fill_index;
  logic [TAG_W-1:0] fill_tag;
  assign fill_index = mem_addr[OFF_W +: IDX_W];
  assign fill_tag   = mem_addr[ADDR_W-1 -: TAG_W];

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic              hit;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_index;
  logic [WSEL_W-1:0] wr_word;
  logic [31:0]       wr_data;
  logic              fill_en;

  assign hit = rd_valid && (rd_tag == cpu_tag);

  dcache_line_array #(
    .LINES  (LINES),
    .WORDS  (WORDS),
    .ADDR_W (ADDR_W)
  ) u_lines (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (cpu_index),
    .rd_word    (cpu_word),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_index   (wr_index),
    .wr_word    (wr_word),
    .wr_data    (wr_data),
    .fill_en    (fill_en),
    .fill_index (fill_index),
    .fill_tag   (fill_tag)
  );

  always_comb begin
    next_state = state;
    cpu_stall  = 1'b0;
    cpu_rdata  = '0;
    wr_en      = 1'b0;
    wr_index   = cpu_index;
    wr_word    = cpu_word;
    wr_data    = cpu_wdata;
    fill_en    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (cpu_write) begin
            cpu_stall  = 1'b1;
            next_state = WRITE;
            wr_en      = hit;
          end else if (cpu_read) begin
            if (hit) begin
              cpu_rdata = rd_data;
            end else begin
              cpu_stall  = 1'b1;
              next_state = REFILL;
            end
          end
        end
        REFILL: begin
          cpu_stall = 1'b1;
          if (mem_ready) begin
            wr_en    = 1'b1;
            wr_index = fill_index;
            wr_word  = beat;
            wr_data  = mem_rdata;
            if (beat == LAST_BEAT) begin
              fill_en    = 1'b1;
              next_state = IDLE;
            end
          end
        end
        WRITE: begin
          cpu_stall = !mem_ready;
          if (mem_ready) begin
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (cpu_write) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= word_addr;
            mem_wdata <= cpu_wdata;
          end else if (cpu_read && !hit) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= line_base;
            beat     <= '0;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            beat <= beat + WSEL_W'(1);
            if (beat == LAST_BEAT) begin
              mem_req <= 1'b0;
            end else begin
              mem_addr <= mem_addr + ADDR_W'(MEM_WORD_BYTES);
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: refill, hits, write-through stores, conflicts, reset abort.
module tb_dcache_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_store [0:1023];

  dcache_ctrl #(.LINES(16), .WORDS(4), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  assign mem_rdata = mem_store[mem_addr[11:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Load that misses: one request cycle, then four ready beats, then the hit.
  task automatic read_miss(input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] base;
    base = {addr[31:4], 4'h0};
    @(negedge clk);
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = addr; mem_ready = 1'b0;
    #1;
    check("miss_stall0", {31'd0, cpu_stall}, 32'd1);
    check("miss_req0", {31'd0, mem_req}, 32'd0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      check("refill_stall", {31'd0, cpu_stall}, 32'd1);
      check("refill_req", {30'd0, mem_req, mem_we}, 32'd2);
      check("refill_addr", mem_addr, base + 32'(4 * b));
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("miss_done_stall", {31'd0, cpu_stall}, 32'd0);
    check("miss_done_req", {31'd0, mem_req}, 32'd0);
    check("miss_rdata", cpu_rdata, exp);
  endtask

  task automatic read_hit(input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = addr; mem_ready = 1'b0;
    #1;
    check("hit_stall", {31'd0, cpu_stall}, 32'd0);
    check("hit_rdata", cpu_rdata, exp);
    check("hit_req", {31'd0, mem_req}, 32'd0);
  endtask

  // Store with mem_ready held off for 'delay' cycles of the write request.
  task automatic store(input logic [31:0] addr, input logic [31:0] data, input int delay);
    @(negedge clk);
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = addr; cpu_wdata = data; mem_ready = 1'b0;
    #1;
    check("st_stall0", {31'd0, cpu_stall}, 32'd1);
    check("st_req0", {31'd0, mem_req}, 32'd0);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      #1;
      check("st_wait_stall", {31'd0, cpu_stall}, 32'd1);
      check("st_wait_req", {30'd0, mem_req, mem_we}, 32'd3);
      check("st_wait_addr", mem_addr, {addr[31:2], 2'b00});
      check("st_wait_wdata", mem_wdata, data);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("st_ready_stall", {31'd0, cpu_stall}, 32'd0);
    check("st_ready_req", {30'd0, mem_req, mem_we}, 32'd3);
    check("st_ready_addr", mem_addr, {addr[31:2], 2'b00});
    check("st_ready_wdata", mem_wdata, data);
    mem_store[addr[11:2]] = data;
    @(negedge clk);
    cpu_write = 1'b0; mem_ready = 1'b0;
    #1;
    check("st_done_req", {30'd0, mem_req, mem_we}, 32'd0);
    check("st_done_stall", {31'd0, cpu_stall}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_store[i] = 32'h5A00_0000 | 32'(i << 2);
    for (int i = 0; i < 4; i++) mem_store[16 + i] = 32'hA0 + 32'(i);

    rst = 1'b1; cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h40;
    cpu_wdata = '0; mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    #1;
    check("rst_memreq", {30'd0, mem_req, mem_we}, 32'd0);
    check("rst_memaddr", mem_addr, 32'd0);
    check("rst_memwdata", mem_wdata, 32'd0);
    rst = 1'b0; cpu_read = 1'b0;

    read_miss(32'h40, 32'hA0);
    read_hit(32'h44, 32'hA1);
    read_hit(32'h48, 32'hA2);
    read_hit(32'h4C, 32'hA3);

    store(32'h48, 32'hDEADBEEF, 3);
    read_hit(32'h48, 32'hDEADBEEF);
    read_hit(32'h44, 32'hA1);

    store(32'h400, 32'h1234_5678, 0);
    read_miss(32'h400, 32'h1234_5678);
    read_hit(32'h404, 32'h5A00_0404);

    read_miss(32'h140, 32'h5A00_0140);
    read_miss(32'h40, 32'hA0);
    read_hit(32'h48, 32'hDEADBEEF);

    // Reset in the third refill beat of line 0x80 abandons the fill.
    @(negedge clk);
    cpu_read = 1'b1; cpu_addr = 32'h84; mem_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      mem_ready = 1'b1;
    end
    @(negedge clk);
    mem_ready = 1'b1; rst = 1'b1;
    #1;
    check("abort_rst_stall", {31'd0, cpu_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0; cpu_read = 1'b0; mem_ready = 1'b0;
    #1;
    check("abort_req", {31'd0, mem_req}, 32'd0);
    check("abort_addr", mem_addr, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      check("idle_ready_req", {31'd0, mem_req}, 32'd0);
      check("idle_ready_stall", {31'd0, cpu_stall}, 32'd0);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    read_miss(32'h84, 32'h5A00_0084);
    read_miss(32'h48, 32'hDEADBEEF);

    @(negedge clk);
    cpu_read = 1'b0; cpu_write = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache. It is the responder to the pipeline's memRead/memWrite requests that the control decoder produces for load/store opcodes, and the initiator toward main memory. It returns load data with zero added latency on a hit. It stalls the pipeline on read misses (line refill) and on every store (write-through).

Parameters:
LINES, 16, number of cache lines; power of 2, minimum 2.
WORDS, 4, 32-bit words per line; power of 2, minimum 2.
ADDR_W, 32, byte-address width.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst  in  1  synchronous, active-high reset.
cpu_read  in  1  load request (decoder memRead); held until cpu_stall low.
cpu_write  in  1  store request (decoder memWrite); held until cpu_stall low.
cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
cpu_wdata  in  32  store data.
cpu_rdata  out  32  load data; valid when cpu_read=1 and cpu_stall=0.
cpu_stall  out  1  freeze pipeline; combinational.
mem_req  out  1  memory request; registered.
mem_we  out  1  1 = write, 0 = read; registered.
mem_addr  out  ADDR_W  word-aligned memory address; registered.
mem_wdata  out  32  write data; registered.
mem_rdata  in  32  read beat data; sampled when mem_req=1, mem_we=0 and mem_ready=1.
mem_ready  in  1  completes one beat/transfer; ignored while mem_req=0.

Behaviour:
- Address split: word select = addr[1+log2(WORDS):2]; index = the next log2(LINES) bits; tag = the remaining upper bits.
- Hit = valid[index] and tag[index] == addr tag.
- Storage: valid bit per line, tag per line, data array of LINES×WORDS words.
- FSM states: IDLE, REFILL, WRITE.
- Reset (synchronous) clears:
  - all valid bits;
  - state to IDLE;
  - mem_req, mem_we, beat counter to 0; mem_addr, mem_wdata to 0.
  - Tag and data contents are don't-care after reset.
  - While rst=1, cpu_stall=0 and cpu_rdata=0.
- IDLE, cpu_read hit, cpu_write=0: cpu_rdata = data[index][word] combinationally; cpu_stall=0; no state change.
- IDLE, cpu_read miss: cpu_stall=1. Next edge: REFILL with mem_req=1, mem_we=0, mem_addr = line base, beat=0.
- REFILL, per cycle:
  - cpu_stall=1.
  - When mem_ready=1: data[index][beat] <= mem_rdata; beat increments; mem_addr advances by 4.
  - On the final beat (beat==WORDS-1 with ready): write tag, set valid, mem_req<=0, go to IDLE.
  - The held load then hits in IDLE.
  - Minimum load-miss latency from request to stall low: WORDS+1 cycles.
- IDLE, cpu_write (hit or miss): cpu_stall=1. Next edge: WRITE with mem_req=1, mem_we=1, mem_addr = cpu_addr word-aligned, mem_wdata = cpu_wdata.
  - On that same edge, a hit updates data[index][word] with cpu_wdata.
  - A miss leaves the cache untouched (no allocate).
- WRITE:
  - cpu_stall = !mem_ready, so stall drops in the cycle mem_ready=1 is seen.
  - At that edge: mem_req<=0, mem_we<=0, state to IDLE. The pipeline advances at that same edge, so the store is never reissued.
- cpu_read and cpu_write both high: treated as a store; the read is ignored.
- mem_req, mem_addr, mem_we and mem_wdata stay stable while mem_req=1 until mem_ready, except mem_addr advancing per accepted beat in REFILL.
- mem_ready while mem_req=0: ignored.
- rst asserted mid-REFILL or mid-WRITE: transfer abandoned; mem_req=0 after the edge; all lines invalid; the partially filled line is not marked valid.
- cpu_addr must be held stable by the pipeline while cpu_stall=1. Behaviour when it changes is undefined, but the FSM must still return to IDLE.

Decomposition:
- Package dcache_pkg holds:
  - the state enum (IDLE, REFILL, WRITE);
  - localparam functions for word-select, index and tag widths derived from LINES, WORDS and ADDR_W;
  - the MEM_WORD_BYTES=4 constant.
- One sub-module, dcache_line_array, holds the valid vector, tag RAM and data RAM.
  - Combinational read port.
  - Write port: word write, or tag+valid set.
  - Synchronous clear-all.
- dcache_ctrl holds the FSM, beat counter and memory-side registers.

Test Plan:
- Reset, then cpu_read at 0x0000_0040 with memory returning 0xA0..0xA3 (ready every cycle): mem_addr steps 0x40, 0x44, 0x48, 0x4C; stall high 5 cycles; cpu_rdata=0xA0.
- Reads at 0x44, 0x48, 0x4C after that fill: stall stays 0; data 0xA1, 0xA2, 0xA3 same cycle.
- Store 0xDEADBEEF to 0x48 (hit), mem_ready delayed 3 cycles: mem_req/mem_we high with mem_addr=0x48 and mem_wdata=0xDEADBEEF held; stall drops in the ready cycle; a following read at 0x48 hits with 0xDEADBEEF.
- Store to 0x400 (miss, LINES=16, WORDS=4): one memory write occurs; a following read of 0x400 misses and refills.
- Conflict: read 0x40, then read 0x140 (same index, different tag), then read 0x40: second and third reads both refill.
- rst pulsed during the third REFILL beat: mem_req=0 next cycle; a subsequent read of that line misses; ready with mem_req=0 causes no change.
